// File: rtl/wt_cache_if.sv
// Core-side and memory-side handshake bundle for the write-through cache controller.
// The master modport is the core/memory environment; the slave modport is the controller.
interface wt_cache_if #(
  parameter int INDEX_W  = 5,
  parameter int OFFSET_W = 2
);
  logic                         cpu_rd;
  logic                         cpu_wr;
  logic [31:0]                  cpu_addr;
  logic [31:0]                  cpu_wdata;
  logic                         hit;
  logic                         stall;
  logic                         cache_we;
  logic [INDEX_W+OFFSET_W-1:0]  cache_waddr;
  logic [31:0]                  cache_wdata;
  logic                         mem_req;
  logic                         mem_we;
  logic [31:0]                  mem_addr;
  logic [31:0]                  mem_wdata;
  logic [31:0]                  mem_rdata;
  logic                         mem_ready;

  modport master (
    output cpu_rd, cpu_wr, cpu_addr, cpu_wdata, mem_rdata, mem_ready,
    input  hit, stall, cache_we, cache_waddr, cache_wdata,
           mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata, mem_rdata, mem_ready,
    output hit, stall, cache_we, cache_waddr, cache_wdata,
           mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/wt_cache_ctrl.sv
// Write-through, no-write-allocate, direct-mapped cache controller.
// Keeps tag/valid state, drives the external data array and main memory,
// and stalls the core while a refill or a memory write is in flight.
// Optional feature: define STATS_EN to add saturating hit/miss/write counters.
module wt_cache_ctrl #(
  parameter int INDEX_W  = 5,
  parameter int OFFSET_W = 2
) (
  input  logic        clk,
  input  logic        reset,
  wt_cache_if.slave   bus
`ifdef STATS_EN
  ,
  output logic [31:0] rd_hit_cnt,
  output logic [31:0] rd_miss_cnt,
  output logic [31:0] wr_cnt
`endif
);

  localparam int LINES = 1 << INDEX_W;
  localparam int TAG_W = 32 - INDEX_W - OFFSET_W - 2;
  localparam logic [OFFSET_W-1:0] LAST_BEAT = '1;

  typedef enum logic [1:0] {IDLE, REFILL, WRITE_MEM, WDONE} state_t;

  state_t                      state, state_nxt;
  logic [LINES-1:0]            valid;
  logic [TAG_W-1:0]            tag_mem [LINES];
  logic [OFFSET_W-1:0]         cnt;

  logic [OFFSET_W-1:0]         off;
  logic [INDEX_W-1:0]          idx;
  logic [TAG_W-1:0]            tag;
  logic                        unused_addr_bits;

  logic                        stall_c, cache_we_c, mem_req_c, mem_we_c;
  logic [INDEX_W+OFFSET_W-1:0] cache_waddr_c;
  logic [31:0]                 cache_wdata_c, mem_addr_c, mem_wdata_c;
  logic                        last_fill;

  assign off = bus.cpu_addr[OFFSET_W+1:2];
  assign idx = bus.cpu_addr[INDEX_W+OFFSET_W+1:OFFSET_W+2];
  assign tag = bus.cpu_addr[31:INDEX_W+OFFSET_W+2];
  // Byte-lane bits are meaningless to a word-organised cache.
  assign unused_addr_bits = ^bus.cpu_addr[1:0];

  assign bus.hit         = valid[idx] && (tag_mem[idx] == tag);
  assign bus.stall       = stall_c;
  assign bus.cache_we    = cache_we_c;
  assign bus.cache_waddr = cache_waddr_c;
  assign bus.cache_wdata = cache_wdata_c;
  assign bus.mem_req     = mem_req_c;
  assign bus.mem_we      = mem_we_c;
  assign bus.mem_addr    = mem_addr_c;
  assign bus.mem_wdata   = mem_wdata_c;

  // Next-state and all bus outputs; memory outputs stay constant within a state
  // because the core holds cpu_* stable while stalled.
  always_comb begin
    state_nxt     = state;
    stall_c       = 1'b0;
    cache_we_c    = 1'b0;
    cache_waddr_c = '0;
    cache_wdata_c = '0;
    mem_req_c     = 1'b0;
    mem_we_c      = 1'b0;
    mem_addr_c    = '0;
    mem_wdata_c   = '0;
    last_fill     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.cpu_wr) begin
          stall_c   = 1'b1;
          state_nxt = WRITE_MEM;
        end else if (bus.cpu_rd && !bus.hit) begin
          stall_c   = 1'b1;
          state_nxt = REFILL;
        end
      end
      REFILL: begin
        stall_c    = 1'b1;
        mem_req_c  = 1'b1;
        mem_addr_c = {tag, idx, cnt, 2'b00};
        if (bus.mem_ready) begin
          cache_we_c    = 1'b1;
          cache_waddr_c = {idx, cnt};
          cache_wdata_c = bus.mem_rdata;
          if (cnt == LAST_BEAT) begin
            last_fill = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      WRITE_MEM: begin
        stall_c     = 1'b1;
        mem_req_c   = 1'b1;
        mem_we_c    = 1'b1;
        mem_addr_c  = {bus.cpu_addr[31:2], 2'b00};
        mem_wdata_c = bus.cpu_wdata;
        if (bus.mem_ready) begin
          if (bus.hit) begin
            cache_we_c    = 1'b1;
            cache_waddr_c = {idx, off};
            cache_wdata_c = bus.cpu_wdata;
          end
          state_nxt = WDONE;
        end
      end
      WDONE: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Beat counter and valid bits; a line becomes valid only once its last beat lands.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      valid <= '0;
    end else begin
      if (state == IDLE && state_nxt == REFILL) cnt <= '0;
      if (state == REFILL && bus.mem_ready) begin
        cnt <= cnt + 1'b1;
        if (cnt == LAST_BEAT) valid[idx] <= 1'b1;
      end
    end
  end

  // Tag array; harmless to write under reset since the valid bit stays clear.
  always_ff @(posedge clk) begin
    if (last_fill) tag_mem[idx] <= tag;
  end

`ifdef STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic refill_done;

  // Event counters; the hit that completes a refilled read is not a true hit.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_hit_cnt  <= '0;
      rd_miss_cnt <= '0;
      wr_cnt      <= '0;
      refill_done <= 1'b0;
    end else begin
      refill_done <= last_fill;
      if (state == IDLE && state_nxt == REFILL)    rd_miss_cnt <= sat_inc(rd_miss_cnt);
      if (state == IDLE && state_nxt == WRITE_MEM) wr_cnt      <= sat_inc(wr_cnt);
      if (state == IDLE && bus.cpu_rd && !bus.cpu_wr && bus.hit && !refill_done)
        rd_hit_cnt <= sat_inc(rd_hit_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_wt_cache_ctrl.sv
// Directed bench for wt_cache_ctrl: cycle table for refill/write-hit, tasks for
// write-miss, conflict eviction and reset abort. Honours STATS_EN when defined.
module tb_wt_cache_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  wt_cache_if #(.INDEX_W(5), .OFFSET_W(2)) bus ();

`ifdef STATS_EN
  logic [31:0] rd_hit_cnt, rd_miss_cnt, wr_cnt;
`endif

  wt_cache_ctrl #(.INDEX_W(5), .OFFSET_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef STATS_EN
    ,
    .rd_hit_cnt  (rd_hit_cnt),
    .rd_miss_cnt (rd_miss_cnt),
    .wr_cnt      (wr_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rd, wr;
    logic [31:0] addr, wdata;
    logic        ready;
    logic [31:0] rdata;
    logic        e_hit, e_stall, e_cwe;
    logic [6:0]  e_cwaddr;
    logic [31:0] e_cwdata;
    logic        e_req, e_mwe;
    logic [31:0] e_maddr, e_mwdata;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  function automatic vec_t mkv(
    input logic rd, wr, input logic [31:0] addr, wdata, input logic ready,
    input logic [31:0] rdata, input logic hit, stall, cwe, input logic [6:0] cwaddr,
    input logic [31:0] cwdata, input logic req, mwe, input logic [31:0] maddr, mwdata);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.ready = ready; v.rdata = rdata;
    v.e_hit = hit; v.e_stall = stall; v.e_cwe = cwe; v.e_cwaddr = cwaddr; v.e_cwdata = cwdata;
    v.e_req = req; v.e_mwe = mwe; v.e_maddr = maddr; v.e_mwdata = mwdata;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, ".stall"},       {31'd0, bus.stall},       32'd0);
    check({tag, ".mem_req"},     {31'd0, bus.mem_req},     32'd0);
    check({tag, ".mem_we"},      {31'd0, bus.mem_we},      32'd0);
    check({tag, ".cache_we"},    {31'd0, bus.cache_we},    32'd0);
    check({tag, ".mem_addr"},    bus.mem_addr,             32'd0);
    check({tag, ".mem_wdata"},   bus.mem_wdata,            32'd0);
    check({tag, ".cache_waddr"}, {25'd0, bus.cache_waddr}, 32'd0);
    check({tag, ".cache_wdata"}, bus.cache_wdata,          32'd0);
  endtask

  // Present one operation, answer every memory request immediately, and return
  // once stall falls (read completing hit, or WDONE for a store).
  task automatic run_op(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata,
                        output logic first_hit, output logic first_stall,
                        output int beats, output int cwe_n,
                        output logic [31:0] first_maddr, output logic saw_mwe,
                        output logic timed_out);
    logic got_req;
    @(negedge clk);
    bus.cpu_rd = rd; bus.cpu_wr = wr; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
    bus.mem_ready = 1'b0;
    #1;
    first_hit = bus.hit; first_stall = bus.stall;
    beats = 0; cwe_n = 0; first_maddr = '0; saw_mwe = 1'b0; timed_out = 1'b1; got_req = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (!bus.stall) begin
        timed_out = 1'b0;
        break;
      end
      if (bus.mem_req) begin
        if (!got_req) first_maddr = bus.mem_addr;
        got_req = 1'b1;
        if (bus.mem_we) saw_mwe = 1'b1;
        bus.mem_rdata = bus.mem_addr ^ 32'h5A5A_0000;
        bus.mem_ready = 1'b1;
        #1;
        beats++;
        if (bus.cache_we) cwe_n++;
      end
      @(negedge clk);
      bus.mem_ready = 1'b0;
      #1;
    end
  endtask

  logic        f_hit, f_stall, s_mwe, t_out;
  int          beats, cwe_n;
  logic [31:0] f_maddr;

  initial begin
    vecs[0]  = mkv(1,0,32'h104,0,           0,0,            0,1,0,7'h00,0,            0,0,0,0);
    vecs[1]  = mkv(1,0,32'h104,0,           0,0,            0,1,0,7'h00,0,            1,0,32'h100,0);
    vecs[2]  = mkv(1,0,32'h104,0,           1,32'h1111_00A0, 0,1,1,7'h40,32'h1111_00A0, 1,0,32'h100,0);
    vecs[3]  = mkv(1,0,32'h104,0,           0,0,            0,1,0,7'h00,0,            1,0,32'h104,0);
    vecs[4]  = mkv(1,0,32'h104,0,           1,32'h2222_00A1, 0,1,1,7'h41,32'h2222_00A1, 1,0,32'h104,0);
    vecs[5]  = mkv(1,0,32'h104,0,           0,0,            0,1,0,7'h00,0,            1,0,32'h108,0);
    vecs[6]  = mkv(1,0,32'h104,0,           1,32'h3333_00A2, 0,1,1,7'h42,32'h3333_00A2, 1,0,32'h108,0);
    vecs[7]  = mkv(1,0,32'h104,0,           0,0,            0,1,0,7'h00,0,            1,0,32'h10C,0);
    vecs[8]  = mkv(1,0,32'h104,0,           1,32'h4444_00A3, 0,1,1,7'h43,32'h4444_00A3, 1,0,32'h10C,0);
    vecs[9]  = mkv(1,0,32'h104,0,           0,0,            1,0,0,7'h00,0,            0,0,0,0);
    vecs[10] = mkv(0,1,32'h108,32'hDEADBEEF,0,0,            1,1,0,7'h00,0,            0,0,0,0);
    vecs[11] = mkv(0,1,32'h108,32'hDEADBEEF,0,0,            1,1,0,7'h00,0,            1,1,32'h108,32'hDEADBEEF);
    vecs[12] = mkv(0,1,32'h108,32'hDEADBEEF,1,0,            1,1,1,7'h42,32'hDEADBEEF, 1,1,32'h108,32'hDEADBEEF);
    vecs[13] = mkv(0,1,32'h108,32'hDEADBEEF,0,0,            1,0,0,7'h00,0,            0,0,0,0);
    vecs[14] = mkv(0,0,32'h000,0,           1,32'h55,       0,0,0,7'h00,0,            0,0,0,0);

    bus.cpu_rd = 0; bus.cpu_wr = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
    bus.mem_rdata = 0; bus.mem_ready = 0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_idle_outputs("reset");
    check("reset.hit", {31'd0, bus.hit}, 32'd0);
`ifdef STATS_EN
    check("reset.rd_hit_cnt",  rd_hit_cnt,  32'd0);
    check("reset.rd_miss_cnt", rd_miss_cnt, 32'd0);
    check("reset.wr_cnt",      wr_cnt,      32'd0);
`endif

    // Refill of 0x104 with ready every 2nd cycle, completing hit, write hit 0x108, WDONE.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      bus.cpu_rd = vecs[i].rd; bus.cpu_wr = vecs[i].wr;
      bus.cpu_addr = vecs[i].addr; bus.cpu_wdata = vecs[i].wdata;
      bus.mem_ready = vecs[i].ready; bus.mem_rdata = vecs[i].rdata;
      #1;
      check($sformatf("row%0d.hit", i),         {31'd0, bus.hit},         {31'd0, vecs[i].e_hit});
      check($sformatf("row%0d.stall", i),       {31'd0, bus.stall},       {31'd0, vecs[i].e_stall});
      check($sformatf("row%0d.cache_we", i),    {31'd0, bus.cache_we},    {31'd0, vecs[i].e_cwe});
      check($sformatf("row%0d.cache_waddr", i), {25'd0, bus.cache_waddr}, {25'd0, vecs[i].e_cwaddr});
      check($sformatf("row%0d.cache_wdata", i), bus.cache_wdata,          vecs[i].e_cwdata);
      check($sformatf("row%0d.mem_req", i),     {31'd0, bus.mem_req},     {31'd0, vecs[i].e_req});
      check($sformatf("row%0d.mem_we", i),      {31'd0, bus.mem_we},      {31'd0, vecs[i].e_mwe});
      check($sformatf("row%0d.mem_addr", i),    bus.mem_addr,             vecs[i].e_maddr);
      check($sformatf("row%0d.mem_wdata", i),   bus.mem_wdata,            vecs[i].e_mwdata);
    end
    bus.mem_ready = 1'b0;

    // Write miss at 0x2000: memory write only, no data-array update, no allocation.
    run_op(0, 1, 32'h2000, 32'h1234_5678, f_hit, f_stall, beats, cwe_n, f_maddr, s_mwe, t_out);
    check("wmiss.timeout",  {31'd0, t_out},   32'd0);
    check("wmiss.hit",      {31'd0, f_hit},   32'd0);
    check("wmiss.stall",    {31'd0, f_stall}, 32'd1);
    check("wmiss.mem_we",   {31'd0, s_mwe},   32'd1);
    check("wmiss.mem_addr", f_maddr,          32'h2000);
    check("wmiss.beats",    beats,            32'd1);
    check("wmiss.cache_we", cwe_n,            32'd0);
    run_op(1, 0, 32'h2000, 0, f_hit, f_stall, beats, cwe_n, f_maddr, s_mwe, t_out);
    check("rd2000.timeout",  {31'd0, t_out},   32'd0);
    check("rd2000.hit",      {31'd0, f_hit},   32'd0);
    check("rd2000.stall",    {31'd0, f_stall}, 32'd1);
    check("rd2000.mem_addr", f_maddr,          32'h2000);
    check("rd2000.mem_we",   {31'd0, s_mwe},   32'd0);
    check("rd2000.beats",    beats,            32'd4);
    check("rd2000.cache_we", cwe_n,            32'd4);
    check("rd2000.done_hit", {31'd0, bus.hit}, 32'd1);

    // Conflict: 0x300 shares the index of 0x100 and evicts it.
    run_op(1, 0, 32'h300, 0, f_hit, f_stall, beats, cwe_n, f_maddr, s_mwe, t_out);
    check("rd300.timeout",  {31'd0, t_out}, 32'd0);
    check("rd300.hit",      {31'd0, f_hit}, 32'd0);
    check("rd300.mem_addr", f_maddr,        32'h300);
    check("rd300.beats",    beats,          32'd4);
    run_op(1, 0, 32'h100, 0, f_hit, f_stall, beats, cwe_n, f_maddr, s_mwe, t_out);
    check("rd100_evicted.hit",      {31'd0, f_hit}, 32'd0);
    check("rd100_evicted.mem_addr", f_maddr,        32'h100);

    // Reset during beat 2 of a refill of 0x300.
    @(negedge clk);
    bus.cpu_rd = 1'b1; bus.cpu_wr = 1'b0; bus.cpu_addr = 32'h300; bus.mem_ready = 1'b0;
    #1;
    check("abort.miss_stall", {31'd0, bus.stall}, 32'd1);
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      bus.mem_ready = 1'b1; bus.mem_rdata = 32'hCAFE_0000 + b;
      #1;
      check($sformatf("abort.beat%0d_we", b), {31'd0, bus.cache_we}, 32'd1);
    end
    @(negedge clk);
    bus.mem_ready = 1'b0;
    #1;
    check("abort.beat2_addr", bus.mem_addr, 32'h308);
    reset = 1'b1;
    bus.cpu_rd = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_idle_outputs("abort");
`ifdef STATS_EN
    check("abort.rd_hit_cnt",  rd_hit_cnt,  32'd0);
    check("abort.rd_miss_cnt", rd_miss_cnt, 32'd0);
    check("abort.wr_cnt",      wr_cnt,      32'd0);
`endif
    run_op(1, 0, 32'h100, 0, f_hit, f_stall, beats, cwe_n, f_maddr, s_mwe, t_out);
    check("reread100.timeout", {31'd0, t_out},   32'd0);
    check("reread100.hit",     {31'd0, f_hit},   32'd0);
    check("reread100.stall",   {31'd0, f_stall}, 32'd1);
    check("reread100.beats",   beats,            32'd4);
    run_op(1, 0, 32'h300, 0, f_hit, f_stall, beats, cwe_n, f_maddr, s_mwe, t_out);
    check("reread300.hit",     {31'd0, f_hit},   32'd0);

    @(negedge clk);
    bus.cpu_rd = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
